// File: rtl/qbert_map_pkg.sv
// Shared types and constants for the Q*bert pyramid map: FSM states, palette and cube geometry helpers.
package qbert_map_pkg;

  typedef enum logic [1:0] {RUN, UPD, FLASH, DONE} map_state_t;

  localparam int DIM_ADD = 50;

  // Level i occupies bits [24i+23:24i] as {R,G,B}.
  localparam logic [95:0] DEFAULT_LVL_RGB = {24'hC800C8, 24'h00C800, 24'h5646EF, 24'hDEDE00};

  // Rank-major index to {rank[31:16], col[15:0]}; rank r (0-based) holds r+1 cubes.
  function automatic logic [31:0] cube_rc(input int idx);
    int r;
    int rem;
    r   = 0;
    rem = idx;
    for (int k = 0; k < 1024; k++) begin
      if (rem > r) begin
        rem = rem - r - 1;
        r   = r + 1;
      end
    end
    return {r[15:0], rem[15:0]};
  endfunction

endpackage

// File: rtl/pyramid_cube_hit.sv
// Hitbox compare for a single cube top at a fixed rank/column of the pyramid.
module pyramid_cube_hit #(
  parameter int RANK = 0,
  parameter int COL  = 0
) (
  input  logic [10:0] x_cnt,
  input  logic [9:0]  y_cnt,
  input  logic [10:0] XLENGTH,
  input  logic [20:0] XYDIAG_DEMI,
  input  logic [20:0] RANK1_XY_OFFSET,
  output logic        hit
);

  localparam logic [10:0] RANK_X = 11'(RANK);
  localparam logic [9:0]  RANK_Y = 10'(RANK);
  localparam logic [9:0]  COL2_Y = 10'(2 * COL);

  logic [10:0] xd, xdr, x_pos, x_lo, x_hi;
  logic [9:0]  yd, ydr, y_pos, y_hi;

  // All positions wrap modulo the screen counter widths.
  assign xd    = XYDIAG_DEMI[20:10];
  assign yd    = XYDIAG_DEMI[9:0];
  assign xdr   = xd - 11'd3;
  assign ydr   = yd - 10'd3;
  assign x_pos = RANK1_XY_OFFSET[20:10] + RANK_X * (xd + XLENGTH);
  assign y_pos = RANK1_XY_OFFSET[9:0] - RANK_Y * yd + COL2_Y * yd;
  assign x_lo  = x_pos - xdr;
  assign x_hi  = x_pos + xdr;
  assign y_hi  = y_pos + ydr + ydr;

  assign hit = (x_cnt >= x_lo) && (x_cnt <= x_hi) && (y_cnt >= y_pos) && (y_cnt <= y_hi);

endmodule

// File: rtl/pyramid_tile_engine.sv
// N_RANK pyramid map: per-cube colour levels driven by landings, win-flash sequence and cube-top pixel path.
module pyramid_tile_engine
  import qbert_map_pkg::*;
#(
  parameter int          N_RANK       = 7,
  parameter int          N_LVL        = 2,
  parameter int          TOGGLE       = 0,
  parameter int          FLASH_PERIOD = 1650000,
  parameter int          N_FLASH      = 8,
  parameter logic [95:0] LVL_RGB      = DEFAULT_LVL_RGB,
  localparam int         N_CUBE       = N_RANK * (N_RANK + 1) / 2,
  localparam int         CW           = $clog2(N_CUBE)
) (
  input  logic                CLK_33,
  input  logic                reset,
  input  logic [10:0]         x_cnt,
  input  logic [9:0]          y_cnt,
  input  logic [10:0]         XLENGTH,
  input  logic [20:0]         XYDIAG_DEMI,
  input  logic [20:0]         RANK1_XY_OFFSET,
  input  logic                land_valid,
  input  logic [CW-1:0]       land_idx,
  output logic                land_ready,
  input  logic                clear_map,
  input  logic                pause,
  output logic [2*N_CUBE-1:0] lvl_state,
  output logic                land_err,
  output logic                top_valid,
  output logic [23:0]         top_RGB,
  output logic                map_done
);

  localparam logic [1:0] TGT = 2'(N_LVL - 1);
  localparam int         PW  = $clog2(FLASH_PERIOD + 1);
  localparam int         FW  = $clog2(N_FLASH + 1);
  localparam int         TW  = $clog2(N_CUBE + 1);

  map_state_t    state_q, state_d;
  logic [1:0]    lvl_q [N_CUBE];
  logic [CW-1:0] idx_q, idx_safe;
  logic          idx_ok, flash_tick;
  logic [1:0]    lvl_old, lvl_new;
  logic [TW-1:0] target_cnt, target_nxt;
  logic [PW-1:0] period_cnt;
  logic [FW-1:0] flash_cnt;

  function automatic logic [1:0] next_level(input logic [1:0] l);
    if (l == TGT) return (TOGGLE != 0) ? 2'd0 : TGT;
    return l + 2'd1;
  endfunction

  function automatic logic [7:0] dim_sat(input logic [7:0] c);
    logic [8:0] s;
    s = {1'b0, c} + 9'(DIM_ADD);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign land_ready = (state_q == RUN) && !pause && !clear_map;
  assign land_err   = (state_q == UPD) && !idx_ok;
  assign map_done   = (state_q == FLASH) || (state_q == DONE);
  assign idx_ok     = int'(idx_q) < N_CUBE;
  assign idx_safe   = idx_ok ? idx_q : '0;
  assign flash_tick = (state_q == FLASH) && !pause && (period_cnt == PW'(FLASH_PERIOD - 1));

  always_comb begin
    lvl_old    = lvl_q[idx_safe];
    lvl_new    = next_level(lvl_old);
    target_nxt = target_cnt;
    if (idx_ok && (lvl_old != TGT) && (lvl_new == TGT)) target_nxt = target_cnt + 1'b1;
    else if (idx_ok && (lvl_old == TGT) && (lvl_new != TGT)) target_nxt = target_cnt - 1'b1;
  end

  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (land_valid && land_ready) state_d = UPD;
      UPD:     state_d = (target_nxt == TW'(N_CUBE)) ? FLASH : RUN;
      FLASH:   if (flash_tick && (flash_cnt == FW'(N_FLASH - 1))) state_d = DONE;
      default: state_d = state_q;
    endcase
    if (clear_map) state_d = RUN;
  end

  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CUBE; i++) lvl_q[i] <= '0;
      idx_q      <= '0;
      target_cnt <= '0;
      period_cnt <= '0;
      flash_cnt  <= '0;
    end else if (clear_map) begin
      for (int i = 0; i < N_CUBE; i++) lvl_q[i] <= '0;
      target_cnt <= '0;
      period_cnt <= '0;
      flash_cnt  <= '0;
    end else begin
      if (land_valid && land_ready) idx_q <= land_idx;
      if (state_q == UPD) begin
        if (idx_ok) lvl_q[idx_safe] <= lvl_new;
        target_cnt <= target_nxt;
      end
      if ((state_q == FLASH) && !pause) begin
        if (flash_tick) begin
          period_cnt <= '0;
          flash_cnt  <= flash_cnt + 1'b1;
        end else begin
          period_cnt <= period_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_CUBE; g++) begin : g_lvl
    assign lvl_state[2*g +: 2] = lvl_q[g];
  end

  logic [N_CUBE-1:0] hit_c, hit_p1;
  logic              vld_p1;
  logic [1:0]        sel_lvl_p1;
  logic [23:0]       pal_p1, rgb_p1;

  for (genvar g = 0; g < N_CUBE; g++) begin : g_cube
    localparam logic [31:0] RC = cube_rc(g);
    pyramid_cube_hit #(.RANK(int'(RC[31:16])), .COL(int'(RC[15:0]))) u_hit (
      .x_cnt           (x_cnt),
      .y_cnt           (y_cnt),
      .XLENGTH         (XLENGTH),
      .XYDIAG_DEMI     (XYDIAG_DEMI),
      .RANK1_XY_OFFSET (RANK1_XY_OFFSET),
      .hit             (hit_c[g])
    );
  end

  // Stage 1: register per-cube hit bits
  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      hit_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      hit_p1 <= hit_c;
      vld_p1 <= |hit_c;
    end
  end

  always_comb begin
    sel_lvl_p1 = '0;
    for (int i = N_CUBE - 1; i >= 0; i--) if (hit_p1[i]) sel_lvl_p1 = lvl_q[i];
    pal_p1 = ((state_q == FLASH) && flash_cnt[0]) ? LVL_RGB[23:0] : LVL_RGB[24*sel_lvl_p1 +: 24];
    rgb_p1 = pause ? {dim_sat(pal_p1[23:16]), dim_sat(pal_p1[15:8]), dim_sat(pal_p1[7:0])} : pal_p1;
  end

  // Stage 2: lowest-index cube colour
  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      top_valid <= 1'b0;
      top_RGB   <= '0;
    end else begin
      top_valid <= vld_p1;
      top_RGB   <= vld_p1 ? rgb_p1 : 24'h0;
    end
  end

endmodule

// File: tb/tb_pyramid_tile_engine.sv
// Scoreboarded bench for pyramid_tile_engine across one-way, flash and toggle configurations.
module tb_pyramid_tile_engine;
  import qbert_map_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] xa, xbc;
  logic [9:0]  ya, ybc;
  logic [10:0] xlen;
  logic [20:0] diag, off;
  logic        lv [3];
  logic        cm [3];
  logic        ps [3];
  logic [4:0]  li [3];
  logic        lr [3];
  logic        le [3];
  logic        tv [3];
  logic        md [3];
  logic [23:0] rgb [3];
  logic [55:0] ls_a, ls_c;
  logic [5:0]  ls_b;
  logic        err;
  logic [23:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  pyramid_tile_engine #(.N_RANK(7)) A (
    .CLK_33(clk), .reset(rst_n), .x_cnt(xa), .y_cnt(ya), .XLENGTH(xlen), .XYDIAG_DEMI(diag),
    .RANK1_XY_OFFSET(off), .land_valid(lv[0]), .land_idx(li[0]), .land_ready(lr[0]),
    .clear_map(cm[0]), .pause(ps[0]), .lvl_state(ls_a), .land_err(le[0]), .top_valid(tv[0]),
    .top_RGB(rgb[0]), .map_done(md[0]));

  pyramid_tile_engine #(.N_RANK(2), .FLASH_PERIOD(4), .N_FLASH(2)) B (
    .CLK_33(clk), .reset(rst_n), .x_cnt(xbc), .y_cnt(ybc), .XLENGTH(xlen), .XYDIAG_DEMI(diag),
    .RANK1_XY_OFFSET(off), .land_valid(lv[1]), .land_idx(li[1][1:0]), .land_ready(lr[1]),
    .clear_map(cm[1]), .pause(ps[1]), .lvl_state(ls_b), .land_err(le[1]), .top_valid(tv[1]),
    .top_RGB(rgb[1]), .map_done(md[1]));

  pyramid_tile_engine #(.N_RANK(7), .N_LVL(3), .TOGGLE(1)) C (
    .CLK_33(clk), .reset(rst_n), .x_cnt(xbc), .y_cnt(ybc), .XLENGTH(xlen), .XYDIAG_DEMI(diag),
    .RANK1_XY_OFFSET(off), .land_valid(lv[2]), .land_idx(li[2]), .land_ready(lr[2]),
    .clear_map(cm[2]), .pause(ps[2]), .lvl_state(ls_c), .land_err(le[2]), .top_valid(tv[2]),
    .top_RGB(rgb[2]), .map_done(md[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pixel driver for instance A: expected colour queued when the pixel is issued.
  task automatic pix(input int x, input int y, input logic hit, input logic [23:0] c);
    @(negedge clk);
    xa = 11'(x);
    ya = 10'(y);
    if (hit) exp_q.push_back(c);
  endtask

  task automatic pix_idle();
    @(negedge clk);
    xa = '0;
    ya = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic land(input int k, input int idx, output logic e);
    int n;
    n = 0;
    @(negedge clk);
    lv[k] = 1'b1;
    li[k] = 5'(idx);
    #1;
    while (!lr[k] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("land_accept", 64'(lr[k]), 64'd1);
    @(negedge clk);
    e     = le[k];
    lv[k] = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    logic [23:0] e;
    if (rst_n === 1'b1 && tv[0] === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: top_RGB=%h with nothing expected", rgb[0]);
      end else begin
        e = exp_q.pop_front();
        if (rgb[0] !== e) begin
          n_fail++;
          $display("FAIL sb_pixel: top_RGB=%h, expected %h", rgb[0], e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    xa = '0; ya = '0;
    xbc = 11'd400; ybc = 10'd110;
    xlen = 11'd0;
    diag = {11'd30, 10'd20};
    off  = {11'd400, 10'd100};
    for (int k = 0; k < 3; k++) begin
      lv[k] = 1'b0; cm[k] = 1'b0; ps[k] = 1'b0; li[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", 64'(lr[k]), 64'd1);
      check("rst_err", 64'(le[k]), 64'd0);
      check("rst_top_valid", 64'(tv[k]), 64'd0);
      check("rst_map_done", 64'(md[k]), 64'd0);
      check("rst_rgb", 64'(rgb[k]), 64'd0);
    end
    check("rst_lvl_a", 64'(ls_a), 64'd0);
    check("rst_lvl_b", 64'(ls_b), 64'd0);
    rst_n = 1'b1;

    // Geometry and lowest-index selection, all levels 0
    pix(400, 110, 1'b1, 24'hDEDE00);
    pix(410, 110, 1'b1, 24'hDEDE00);
    pix(440,  90, 1'b1, 24'hDEDE00);
    pix(373, 100, 1'b1, 24'hDEDE00);
    pix(372, 100, 1'b0, 24'h0);
    pix(400,  99, 1'b0, 24'h0);
    pix(440, 150, 1'b1, 24'hDEDE00);
    pix_idle();

    // One-way, N_LVL=2: second landing saturates
    land(0, 0, err);
    check("a_lvl0_first", 64'(ls_a[1:0]), 64'd1);
    check("a_tcnt_first", 64'(A.target_cnt), 64'd1);
    land(0, 0, err);
    check("a_lvl0_second", 64'(ls_a[1:0]), 64'd1);
    check("a_tcnt_second", 64'(A.target_cnt), 64'd1);

    pix(400, 110, 1'b1, 24'h5646EF);
    pix(410, 110, 1'b1, 24'h5646EF);
    pix(440,  90, 1'b1, 24'hDEDE00);
    pix(373, 100, 1'b1, 24'h5646EF);
    pix(440, 150, 1'b1, 24'hDEDE00);
    pix_idle();

    ps[0] = 1'b1;
    pix(400, 110, 1'b1, 24'h8878FF);
    #1 check("a_pause_ready", 64'(lr[0]), 64'd0);
    pix(440,  90, 1'b1, 24'hFFFF32);
    pix(372, 100, 1'b0, 24'h0);
    pix(440, 150, 1'b1, 24'hFFFF32);
    pix_idle();
    ps[0] = 1'b0;

    // Map completion and flash timing on the 2-rank pyramid
    land(1, 0, err);
    land(1, 1, err);
    check("b_not_done", 64'(md[1]), 64'd0);
    land(1, 2, err);
    check("b_map_done", 64'(md[1]), 64'd1);
    check("b_state_flash", 64'(B.state_q), 64'(FLASH));
    repeat (3) @(negedge clk);
    check("b_flash_even_rgb", 64'(rgb[1]), 64'h5646EF);
    repeat (3) @(negedge clk);
    check("b_flash_odd_rgb", 64'(rgb[1]), 64'hDEDE00);
    @(negedge clk);
    check("b_still_flash", 64'(B.state_q), 64'(FLASH));
    @(negedge clk);
    check("b_state_done", 64'(B.state_q), 64'(DONE));
    check("b_done_map_done", 64'(md[1]), 64'd1);
    @(negedge clk);
    cm[1] = 1'b1;
    @(negedge clk);
    cm[1] = 1'b0;
    #1;
    check("b_clr_done_lvl", 64'(ls_b), 64'd0);
    check("b_clr_done_ready", 64'(lr[1]), 64'd1);

    // clear_map while UPD is pending
    @(negedge clk);
    lv[1] = 1'b1; li[1] = 5'd0;
    @(negedge clk);
    check("b_state_upd", 64'(B.state_q), 64'(UPD));
    cm[1] = 1'b1; lv[1] = 1'b0;
    @(negedge clk);
    cm[1] = 1'b0;
    #1;
    check("b_clr_upd_lvl", 64'(ls_b), 64'd0);
    check("b_clr_upd_state", 64'(B.state_q), 64'(RUN));
    check("b_clr_upd_ready", 64'(lr[1]), 64'd1);

    // clear_map while flashing
    land(1, 0, err);
    land(1, 1, err);
    land(1, 2, err);
    check("b_reflash", 64'(md[1]), 64'd1);
    cm[1] = 1'b1;
    @(negedge clk);
    cm[1] = 1'b0;
    #1;
    check("b_clr_flash_lvl", 64'(ls_b), 64'd0);
    check("b_clr_flash_done", 64'(md[1]), 64'd0);
    check("b_clr_flash_ready", 64'(lr[1]), 64'd1);
    check("b_clr_flash_tcnt", 64'(B.target_cnt), 64'd0);

    // Toggle mode, N_LVL=3 on cube 4
    land(2, 4, err);
    check("c_lvl_1", 64'(ls_c[9:8]), 64'd1);
    check("c_tcnt_1", 64'(C.target_cnt), 64'd0);
    land(2, 4, err);
    check("c_lvl_2", 64'(ls_c[9:8]), 64'd2);
    check("c_tcnt_2", 64'(C.target_cnt), 64'd1);
    land(2, 4, err);
    check("c_lvl_wrap", 64'(ls_c[9:8]), 64'd0);
    check("c_tcnt_wrap", 64'(C.target_cnt), 64'd0);
    land(2, 4, err);
    check("c_lvl_again", 64'(ls_c), 64'h100);

    // Out-of-range index
    land(2, 28, err);
    check("c_err_pulse", 64'(err), 64'd1);
    check("c_err_cleared", 64'(le[2]), 64'd0);
    check("c_oor_lvl", 64'(ls_c), 64'h100);

    // Landing held through pause is taken afterwards
    ps[2] = 1'b1;
    @(negedge clk);
    lv[2] = 1'b1; li[2] = 5'd4;
    #1 check("c_pause_ready", 64'(lr[2]), 64'd0);
    repeat (3) @(negedge clk);
    check("c_pause_lvl", 64'(ls_c), 64'h100);
    ps[2] = 1'b0;
    @(negedge clk);
    lv[2] = 1'b0;
    @(negedge clk);
    check("c_unpause_lvl", 64'(ls_c[9:8]), 64'd2);

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
